// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill controller: fill FSM encoding,
// cache-owner encoding and block geometry.
package cache_pkg;

    localparam int WORDS          = 8;
    localparam int BLOCK_OFFSET_W = 4;
    localparam int CNT_W          = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fill_state_e;

    typedef enum logic {
        OWNER_D = 1'b0,
        OWNER_I = 1'b1
    } owner_e;

endpackage

// File: rtl/fill_word_counter.sv
// Word index within a block refill: synchronous clear, increment, and a flag
// marking the final word of the block.
module fill_word_counter
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state takes non-blocking assignments so every flop samples the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == {CNT_W{1'b1}});

endmodule

// File: rtl/rca_16bit.sv
// Ripple-carry adder used for block-base plus word-offset address formation.
// The carry out of the top bit is discarded, so sums wrap modulo 2^W.
module rca_16bit #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum
);

    logic [W-1:0] carry;

    assign carry[0] = cin;

    for (genvar g = 0; g < W; g++) begin : g_bit
        assign sum[g] = a[g] ^ b[g] ^ carry[g];
        if (g < W - 1) begin : g_carry
            assign carry[g+1] = (a[g] & b[g]) | (carry[g] & (a[g] ^ b[g]));
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Block-refill sequencer for the I and D caches over one shared pipelined
// memory read port: arbitrate, issue eight word reads, steer returns, write tags.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dmiss,
    input  logic [ADDR_WIDTH-1:0] dmiss_addr,
    input  logic                  imiss,
    input  logic [ADDR_WIDTH-1:0] imiss_addr,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_data_valid,
    input  logic [15:0]           mem_data,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [15:0]           fill_data,
    output logic                  d_data_wr,
    output logic                  i_data_wr,
    output logic                  d_tag_wr,
    output logic                  i_tag_wr,
    output logic                  d_busy,
    output logic                  i_busy
);

    localparam int BASE_W = ADDR_WIDTH - BLOCK_OFFSET_W;

    fill_state_e           state_q, state_d;
    owner_e                owner_q, owner_d;
    logic [BASE_W-1:0]     base_q, base_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic                  rx_done_q, rx_done_d;

    logic                  issue_clr, issue_inc, issue_last;
    logic                  recv_clr, recv_inc, recv_last;
    logic [CNT_W-1:0]      issue_cnt, recv_cnt;
    logic [ADDR_WIDTH-1:0] block_addr, issue_addr, recv_addr;
    logic                  grant, wr_fire;
    logic [ADDR_WIDTH-1:0] req_addr;

    fill_word_counter u_issue_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (issue_clr),
        .inc  (issue_inc),
        .cnt  (issue_cnt),
        .last (issue_last)
    );

    fill_word_counter u_recv_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (recv_clr),
        .inc  (recv_inc),
        .cnt  (recv_cnt),
        .last (recv_last)
    );

    assign block_addr = {base_q, {BLOCK_OFFSET_W{1'b0}}};

    rca_16bit #(.W(ADDR_WIDTH)) u_issue_add (
        .a   (block_addr),
        .b   ({{BASE_W{1'b0}}, issue_cnt, 1'b0}),
        .cin (1'b0),
        .sum (issue_addr)
    );

    rca_16bit #(.W(ADDR_WIDTH)) u_recv_add (
        .a   (block_addr),
        .b   ({{BASE_W{1'b0}}, recv_cnt, 1'b0}),
        .cin (1'b0),
        .sum (recv_addr)
    );

    assign grant    = dmiss | imiss;
    assign req_addr = dmiss ? dmiss_addr : imiss_addr;

    // rx_done_q stops the wrapped receive counter from accepting a ninth word.
    assign wr_fire = ((state_q == ISSUE) || (state_q == DRAIN)) && mem_data_valid && !rx_done_q;

    // NOTE: every signal gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        base_d      = base_q;
        miss_addr_d = miss_addr_q;
        rx_done_d   = rx_done_q;
        issue_clr   = 1'b0;
        issue_inc   = 1'b0;
        recv_clr    = 1'b0;
        recv_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d     = dmiss ? OWNER_D : OWNER_I;
                    miss_addr_d = req_addr;
                    base_d      = req_addr[ADDR_WIDTH-1:BLOCK_OFFSET_W];
                    rx_done_d   = 1'b0;
                    issue_clr   = 1'b1;
                    recv_clr    = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                issue_inc = 1'b1;
                if (issue_last) begin
                    state_d = (rx_done_q || (wr_fire && recv_last)) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (wr_fire && recv_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (wr_fire) begin
            recv_inc = 1'b1;
            if (recv_last) begin
                rx_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_D;
            base_q      <= '0;
            miss_addr_q <= '0;
            rx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            base_q      <= base_d;
            miss_addr_q <= miss_addr_d;
            rx_done_q   <= rx_done_d;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        fill_addr = '0;
        fill_data = '0;
        d_data_wr = 1'b0;
        i_data_wr = 1'b0;
        d_tag_wr  = 1'b0;
        i_tag_wr  = 1'b0;

        if (state_q == ISSUE) begin
            mem_en   = 1'b1;
            mem_addr = issue_addr;
        end

        if (wr_fire) begin
            fill_addr = recv_addr;
            fill_data = mem_data;
            d_data_wr = (owner_q == OWNER_D);
            i_data_wr = (owner_q == OWNER_I);
        end else if (state_q == DONE) begin
            fill_addr = miss_addr_q;
            d_tag_wr  = (owner_q == OWNER_D);
            i_tag_wr  = (owner_q == OWNER_I);
        end
    end

    assign d_busy = (state_q != IDLE) && (owner_q == OWNER_D);
    assign i_busy = (state_q != IDLE) && (owner_q == OWNER_I);

endmodule

// File: doc/cache_fill_ctrl.md
# cache_fill_ctrl

Miss-handling controller that sequences block refills for the instruction and data caches over one shared, pipelined main-memory read port. On a cache miss it arbitrates between the two caches. It then issues the eight word reads of the 16-byte block, steers each returned word into the owning cache's data array, and finally writes that cache's tag/valid/LRU metadata. It sits between the two cache instances and the memory module, and its busy outputs stall the pipeline.

## Interface
- ADDR_WIDTH, 16, byte-address width
- WORDS, 8, 16-bit words per block; offset width is log2(WORDS*2) = 4
- MEM_LATENCY, 4, cycles from mem_en to mem_data_valid; informational, the controller counts valid strobes and never assumes latency
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- dmiss  in  1  data-cache miss request, held until fill done
- dmiss_addr  in  ADDR_WIDTH  missing byte address (D)
- imiss  in  1  instruction-cache miss request, held until fill done
- imiss_addr  in  ADDR_WIDTH  missing byte address (I)
- mem_en  out  1  read-issue strobe to memory
- mem_addr  out  ADDR_WIDTH  word address being issued
- mem_data_valid  in  1  returned word valid
- mem_data  in  16  returned word
- fill_addr  out  ADDR_WIDTH  cache address for the current data/tag write
- fill_data  out  16  mem_data passed through
- d_data_wr / i_data_wr  out  1  data-array write enable, D / I cache
- d_tag_wr / i_tag_wr  out  1  metadata write enable, D / I cache
- d_busy / i_busy  out  1  fill in progress for that cache

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. Registers: owner (0 = D, 1 = I), base[ADDR_WIDTH-1:4], miss_addr, issue_cnt[2:0], recv_cnt[2:0].
- IDLE: requests are sampled only in this state. dmiss has priority over imiss.
  - On a grant, latch owner, miss_addr, and base = addr with [3:0] cleared. Clear both counters and go to ISSUE.
  - mem_data_valid is ignored in IDLE.
- ISSUE: assert mem_en with mem_addr = base + {issue_cnt,1'b0}, then increment issue_cnt. After the eighth issue (issue_cnt == 7), go to DRAIN.
- Receive path, active in ISSUE and DRAIN:
  - On each mem_data_valid, assert the owner's data_wr with fill_addr = base + {recv_cnt,1'b0} and fill_data = mem_data, then increment recv_cnt.
  - The eighth valid moves the FSM to DONE. If the eighth valid arrives while still in ISSUE (only when latency is 0), go straight to DONE once issuing completes.
- DONE, one cycle: assert the owner's tag_wr with fill_addr = miss_addr so the cache latches tag, valid = 1 and the new LRU bit. Then go to IDLE.
- busy for the owner is high in ISSUE, DRAIN and DONE. The cache holds its miss_detected while tag_wr is high.
- Valid strobes beyond the eighth in one fill are ignored.
- A request dropping mid-fill does not abort the fill; the fill completes normally.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Offset concatenation never carries into base.

## Timing
- Reset (rst low, asynchronous): state IDLE, counters 0. All outputs 0: mem_en, mem_addr, fill_addr, fill_data, all *_wr, all *_busy.
- Reset mid-fill aborts immediately. Memory data still in flight after reset release arrives in IDLE and is dropped.
- Request high in IDLE at cycle 0 gives:
  - ISSUE cycles 1–8;
  - busy high from cycle 1;
  - with MEM_LATENCY = 4, data writes in cycles 5–12, DRAIN from cycle 9, DONE at 13, IDLE at 14.
- Requests are granted one fill at a time. A request pending at the DONE→IDLE transition is granted in the first IDLE cycle (one cycle of IDLE between fills).
- A data write and a tag write never occur in the same cycle.
- mem_en, the data_wr signals and the tag_wr signals are single-cycle, registered-state decodes. fill_data is combinational from mem_data.

## Structure
- Shared package cache_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2, DONE=2'd3), OWNER_D/OWNER_I constants, and BLOCK_OFFSET_W = 4.
- One sub-module, fill_word_counter: a 3-bit counter with clear, increment and a last flag. It is instantiated twice, for issue and receive.
- The existing rca_16bit adder forms base + offset.

## Test plan
- Single D miss, dmiss_addr = 16'h1234, latency 4:
  - mem_addr issues 1230, 1232 … 123E in cycles 1–8;
  - d_data_wr fill_addr follows the same sequence in cycles 5–12;
  - d_tag_wr at cycle 13 with fill_addr = 1234;
  - i_* outputs stay 0.
- Simultaneous dmiss (16'h0040) and imiss (16'h8000):
  - the D fill completes first;
  - the I fill begins issuing 8000 the cycle after returning to IDLE;
  - i_busy stays 0 during the D fill.
- Bursty memory with valid gaps (valid on cycles 5, 7, 8, 11, 12, 13, 15, 16): eight writes in order, then DONE at cycle 17. No extra writes.
- Wrap: dmiss_addr = 16'hFFFA → issues FFF0 … FFFE; no carry beyond FFFE.
- Reset asserted at cycle 6 of a fill:
  - all outputs 0 at once;
  - valid strobes after release produce no *_wr;
  - the next dmiss restarts issuing at word 0.
- Extra valid strobe after the eighth word, and dmiss dropped mid-fill: the strobe is ignored, the fill still completes, and tag_wr pulses once.
